mul_scheduler: RTL and testbench

Round-robin scheduler that shares one sequential 8-bit shift-add multiplier (init/done handshake, 16-bit product) among several requesters. It accepts operand pairs over a valid/ready handshake, issues exactly one multiplication at a time, and watches completion with a watchdog. It returns each product to its requester as a one-cycle response pulse. It sits between client logic and the existing multiplier top level, and is the only block that drives the multiplier's `init`.

---
 rtl/mul_sched_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/mul_scheduler.sv | 145 ++++++++++++++
 tb/tb_mul_scheduler.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_sched_pkg.sv
// Shared types and defaults for the multiplier scheduler.
package mul_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } sched_state_t;

  localparam int MS_WIDTH   = 8;
  localparam int MS_TIMEOUT = 24;
  localparam int MS_CNT_W   = $clog2(MS_TIMEOUT + 1);

  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or above ptr, wrapping.
// Zero latency; grant is empty when no requester is valid.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_idx
);
  localparam int IDX_W = $clog2(N_REQ);

  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    // k is the distance from ptr; the smallest distance with a valid request wins
    for (int k = 0; k < N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!found && req_valid[i] && (i == ((int'(ptr) + k) % N_REQ))) begin
          found   = 1'b1;
          gnt[i]  = 1'b1;
          gnt_idx = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/mul_scheduler.sv
// Shares one sequential multiplier among N_REQ requesters, one operation at a time, with a watchdog.
// Accept->response: 1 cycle for zero operands, done+1 otherwise; req_ready only in IDLE (one-hot).
module mul_scheduler
  import mul_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = MS_WIDTH,
  parameter int TIMEOUT = MS_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [2*WIDTH-1:0]     rsp_data,
  output logic                   rsp_err,
  output logic                   mul_init,
  output logic [WIDTH-1:0]       mul_a,
  output logic [WIDTH-1:0]       mul_b,
  input  logic                   mul_done,
  input  logic [2*WIDTH-1:0]     mul_product
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = cnt_width(TIMEOUT);

  sched_state_t         state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     id_q, id_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic                 err_q, err_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [N_REQ-1:0]     gnt;
  logic [IDX_W-1:0]     gnt_idx;
  logic [WIDTH-1:0]     sel_a, sel_b;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (|gnt) begin
          a_d   = sel_a;
          b_d   = sel_b;
          id_d  = gnt_idx;
          ptr_d = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
          // A zero operand has a known product, so the multiplier is never started
          if (sel_a == '0 || sel_b == '0) begin
            prod_d  = '0;
            err_d   = 1'b0;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (mul_done) begin
          prod_d  = mul_product;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // rst_n gates ready so nothing is offered while reset is held
  assign req_ready = (state_q == IDLE && rst_n) ? gnt : '0;
  assign mul_init  = (state_q == ISSUE);
  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign rsp_data  = (state_q == RESP) ? prod_q : '0;
  assign rsp_err   = (state_q == RESP) ? err_q : 1'b0;

  always_comb begin
    rsp_valid = '0;
    if (state_q == RESP) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (id_q == IDX_W'(i)) rsp_valid[i] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mul_scheduler.sv
// Self-checking bench for mul_scheduler: directed vector table, corner sequences, randomized model run.
module tb_mul_scheduler;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 24;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid, req_ready, rsp_valid;
  logic [N*W-1:0] req_a, req_b;
  logic [2*W-1:0] rsp_data, mul_product;
  logic           rsp_err, mul_init, mul_done;
  logic [W-1:0]   mul_a, mul_b;

  mul_scheduler #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .mul_init    (mul_init),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_done    (mul_done),
    .mul_product (mul_product)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Behavioural multiplier: done pulses mul_lat cycles after init; never/force modes for corner cases
  int          mul_lat   = 9;
  bit          mul_never = 1'b0;
  bit          mul_force = 1'b0;
  int          m_cnt     = 0;
  logic [15:0] m_p       = 16'h0;

  initial begin
    bit fire;
    mul_done    = 1'b0;
    mul_product = 16'hBEEF;
    forever begin
      @(negedge clk);
      fire = 1'b0;
      if (mul_init) begin
        m_cnt = mul_lat;
        m_p   = mul_a * mul_b;
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) fire = 1'b1;
      end
      mul_done = mul_force | (fire & !mul_never);
      if (mul_done) mul_product = m_p;
    end
  end

  function automatic int oh_idx(input logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (v[i] && r < 0) r = i;
    return r;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    int r = -1;
    for (int k = 0; k < N; k++) if (r < 0 && v[(p + k) % N]) r = (p + k) % N;
    return r;
  endfunction

  task automatic set_req(input int id, input int a, input int b);
    req_a[id*W +: W] = W'(a);
    req_b[id*W +: W] = W'(b);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    int id; int a; int b; int lat; int mode;
    int exp_data; int exp_err; int exp_lat; int exp_init;
  } vec_t;

  task automatic run_one(input vec_t v);
    bit got = 1'b0;
    int ninit = 0;
    int init_at = -1;
    @(negedge clk);
    mul_lat   = v.lat;
    mul_never = (v.mode == 1);
    mul_force = (v.mode == 2);
    set_req(v.id, v.a, v.b);
    req_valid       = '0;
    req_valid[v.id] = 1'b1;
    #1 chk("vec_ready", req_ready, 32'(1) << v.id);
    for (int k = 1; k <= 100 && !got; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = '0;
      #1;
      if (mul_init) begin
        ninit++;
        if (init_at < 0) init_at = k;
      end
      if (rsp_valid != '0) begin
        got = 1'b1;
        chk("vec_rsp_valid", rsp_valid, 32'(1) << v.id);
        chk("vec_rsp_data", rsp_data, v.exp_data);
        chk("vec_rsp_err", rsp_err, v.exp_err);
        chk("vec_rsp_latency", k, v.exp_lat);
      end
    end
    chk("vec_rsp_seen", got, 1);
    chk("vec_init_count", ninit, v.exp_init);
    if (v.exp_init != 0) chk("vec_init_cycle", init_at, 1);
    mul_never = 1'b0;
    mul_force = 1'b0;
  endtask

  // Randomized phase state: requester side plus transaction-level model
  bit pend[N];
  int ra[N];
  int rb[N];
  int ptr_m = 0;
  bit busy  = 1'b0;
  bit stop  = 1'b0;
  int qid[$];
  int qdat[$];

  function automatic bit any_pend();
    bit r = 1'b0;
    for (int i = 0; i < N; i++) r |= pend[i];
    return r;
  endfunction

  task automatic rand_step();
    bit resp_now;
    int win;
    @(negedge clk);
    resp_now = (rsp_valid != '0);
    if (resp_now) begin
      chk("rand_rsp_pending", qid.size(), 1);
      if (qid.size() > 0) begin
        chk("rand_rsp_id", rsp_valid, 32'(1) << qid[0]);
        chk("rand_rsp_data", rsp_data, qdat[0]);
        chk("rand_rsp_err", rsp_err, 0);
        void'(qid.pop_front());
        void'(qdat.pop_front());
      end
    end
    for (int i = 0; i < N; i++) begin
      if (pend[i]) begin
        if (!stop && $urandom_range(0, 31) == 0) pend[i] = 1'b0;
      end else if (!stop && $urandom_range(0, 3) == 0) begin
        pend[i] = 1'b1;
        ra[i]   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
        rb[i]   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
      end
      req_valid[i] = pend[i];
      set_req(i, ra[i], rb[i]);
    end
    #1;
    win = busy ? -1 : rr_pick(req_valid, ptr_m);
    chk("rand_ready", req_ready, (win < 0) ? 32'(0) : (32'(1) << win));
    if (win >= 0) begin
      qid.push_back(win);
      qdat.push_back(ra[win] * rb[win]);
      ptr_m     = (win + 1) % N;
      busy      = 1'b1;
      pend[win] = 1'b0;
      mul_lat   = $urandom_range(1, 12);
    end
    if (resp_now) busy = 1'b0;
  endtask

  initial begin
    vec_t tbl[9];
    int   rr_a[4];
    int   rr_b[4];
    int   rr_ord[5];
    int   ng, nr, r, quiet;
    bit   got;

    tbl[0] = '{0, 13, 11, 9, 0, 143, 0, 11, 1};
    tbl[1] = '{2, 0, 200, 1, 0, 0, 0, 1, 0};
    tbl[2] = '{1, 5, 6, 1, 1, 0, 1, TO + 2, 1};
    tbl[3] = '{1, 5, 6, 3, 0, 30, 0, 5, 1};
    tbl[4] = '{3, 255, 255, 1, 0, 65025, 0, 3, 1};
    tbl[5] = '{0, 3, 4, 2, 2, 12, 0, 3, 1};
    tbl[6] = '{3, 7, 0, 1, 0, 0, 0, 1, 0};
    tbl[7] = '{2, 3, 4, TO, 0, 12, 0, TO + 2, 1};
    tbl[8] = '{1, 9, 9, TO + 1, 0, 0, 1, TO + 2, 1};
    rr_a   = '{13, 20, 100, 255};
    rr_b   = '{11, 30, 7, 255};
    rr_ord = '{0, 1, 2, 3, 0};

    rst_n     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    #2 rst_n  = 1'b0;
    req_valid = '1;
    set_req(0, 1, 1);
    repeat (2) @(negedge clk);
    #1;
    chk("reset_req_ready", req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_rsp_err", rsp_err, 0);
    chk("reset_mul_init", mul_init, 0);
    chk("reset_mul_ab", {mul_a, mul_b}, 0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_one(tbl[i]);

    // Round-robin with all requesters valid continuously
    do_reset();
    mul_lat = 4;
    @(negedge clk);
    for (int i = 0; i < N; i++) set_req(i, rr_a[i], rr_b[i]);
    req_valid = '1;
    ng = 0;
    nr = 0;
    for (int c = 0; c < 300 && nr < 5; c++) begin
      #1;
      if ((req_ready & req_valid) != '0 && ng < 5) begin
        chk("rr_grant", oh_idx(req_ready), rr_ord[ng]);
        ng++;
      end
      if (rsp_valid != '0) begin
        r = oh_idx(rsp_valid);
        chk("rr_rsp_id", r, rr_ord[nr]);
        chk("rr_rsp_data", rsp_data, rr_a[r] * rr_b[r]);
        nr++;
        if (nr == 5) req_valid = '0;
      end
      if (nr < 5) @(negedge clk);
    end
    chk("rr_rsp_count", nr, 5);

    // Reset while waiting on the multiplier
    mul_lat = 20;
    @(negedge clk);
    set_req(1, 9, 9);
    req_valid = 4'b0010;
    #1 chk("rst_pre_ready", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    #1 chk("rst_issue_init", mul_init, 1);
    repeat (2) @(negedge clk);
    req_valid = 4'b0101;
    rst_n     = 1'b0;
    #1;
    chk("rst_async_ready", req_ready, 0);
    chk("rst_async_init", mul_init, 0);
    chk("rst_async_ab", {mul_a, mul_b}, 0);
    chk("rst_async_rsp", {rsp_valid, rsp_err, rsp_data}, 0);
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    quiet = 0;
    repeat (30) begin
      @(negedge clk);
      #1;
      if (rsp_valid != '0 || mul_init) quiet++;
    end
    chk("rst_no_response", quiet, 0);
    @(negedge clk);
    set_req(0, 6, 7);
    set_req(2, 8, 8);
    req_valid = 4'b0101;
    #1 chk("rst_ptr_zero", req_ready, 4'b0001);
    mul_lat = 2;
    got = 1'b0;
    for (int k = 1; k <= 50 && !got; k++) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      if (rsp_valid != '0) begin
        got = 1'b1;
        chk("rst_after_rsp", rsp_valid, 4'b0001);
        chk("rst_after_data", rsp_data, 42);
      end
    end
    chk("rst_after_seen", got, 1);

    // Randomized traffic against the transaction-level model
    do_reset();
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      ra[i]   = 0;
      rb[i]   = 0;
    end
    ptr_m = 0;
    busy  = 1'b0;
    stop  = 1'b0;
    for (int c = 0; c < 3000; c++) rand_step();
    stop = 1'b1;
    for (int c = 0; c < 600 && (busy || qid.size() != 0 || any_pend()); c++) rand_step();
    chk("rand_drained", busy || qid.size() != 0 || any_pend(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
